// File: rtl/transmitter_pkg.sv
// Shared constants and state encoding for the serial transmitter/receiver pair.
//   DEFAULT_OVERSAMPLE : clocks per serial bit (receiver samples 16x)
//   DEFAULT_DATA_BITS  : data bits per frame
//   FRAME_BITS         : start + data + stop
//   tx_state_t         : FSM encoding shared with the receiver and its benches
package transmitter_pkg;

   localparam int unsigned DEFAULT_OVERSAMPLE = 16;
   localparam int unsigned DEFAULT_DATA_BITS  = 8;
   localparam int unsigned FRAME_BITS         = DEFAULT_DATA_BITS + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/tx_sample_counter.sv
// Modulo-OVERSAMPLE sample counter; bit_tick_c marks the last clock of a bit.
//   clk, rst    : clock, async active-high reset
//   clear       : hold count at 0 (line idle)
//   count       : current sample index within the bit, 0..OVERSAMPLE-1
//   bit_tick_c  : combinational, high while count == OVERSAMPLE-1
module tx_sample_counter #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             bit_tick_c
);

   assign bit_tick_c = (count == CNT_W'(OVERSAMPLE - 1));

   // Wrap to 0 on the tick so consecutive bits are exactly OVERSAMPLE clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear || bit_tick_c) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/transmitter.sv
// Serial character transmitter: 8N1-style frames (start 0, data LSB first, stop 1),
// each bit held OVERSAMPLE clocks, with a one-character holding buffer.
//   clk, rst       : clock, async active-high reset
//   data_in        : parallel character, taken when load & ready
//   load           : request to accept data_in
//   ready          : holding buffer empty
//   data_out       : registered serial line, idles high
//   busy           : frame in progress
//   character_sent : one-cycle pulse in the final clock of each stop bit
module transmitter
   import transmitter_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 load,
   output logic                 ready,
   output logic                 data_out,
   output logic                 busy,
   output logic                 character_sent
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 data_out_q, data_out_d;
   logic                 sent_q, sent_d;
   logic                 ready_q;
   logic                 busy_q;

   logic [CNT_W-1:0]     sample_cnt;
   logic                 bit_tick_c;
   logic                 accept_c;

   assign accept_c = load & ready_q;

   // Counter is held at 0 while idle so the start bit gets a full OVERSAMPLE clocks.
   tx_sample_counter #(
      .OVERSAMPLE (OVERSAMPLE),
      .CNT_W      (CNT_W)
   ) u_sample_counter (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_q == IDLE),
      .count      (sample_cnt),
      .bit_tick_c (bit_tick_c)
   );

   // Next-state, datapath and output decode.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      bit_cnt_d   = bit_cnt_q;
      data_out_d  = data_out_q;

      case (state_q)
         IDLE: begin
            // Line is free: go straight to the shift register, buffer untouched.
            if (accept_c) begin
               shift_d    = data_in;
               state_d    = START;
               data_out_d = 1'b0;
            end
         end
         START: begin
            if (accept_c) begin
               hold_d      = data_in;
               hold_full_d = 1'b1;
            end
            if (bit_tick_c) begin
               state_d    = DATA;
               bit_cnt_d  = '0;
               data_out_d = shift_q[0];
            end
         end
         DATA: begin
            if (accept_c) begin
               hold_d      = data_in;
               hold_full_d = 1'b1;
            end
            if (bit_tick_c) begin
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  state_d    = STOP;
                  data_out_d = 1'b1;
               end else begin
                  shift_d    = shift_q >> 1;
                  bit_cnt_d  = bit_cnt_q + 1'b1;
                  data_out_d = shift_d[0];
               end
            end
         end
         STOP: begin
            if (bit_tick_c) begin
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = 1'b0;
                  state_d     = START;
                  data_out_d  = 1'b0;
               end else if (accept_c) begin
                  // Load landing on the last stop clock with an empty buffer
                  // starts the next frame directly rather than stranding it.
                  shift_d    = data_in;
                  state_d    = START;
                  data_out_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (accept_c) begin
               hold_d      = data_in;
               hold_full_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Registered one clock early so the pulse lines up with the stop-bit tick.
      sent_d = (state_q == STOP) && (sample_cnt == CNT_W'(OVERSAMPLE - 2));
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= '0;
         data_out_q  <= 1'b1;
         sent_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         data_out_q  <= data_out_d;
         sent_q      <= sent_d;
         ready_q     <= ~hold_full_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign ready          = ready_q;
   assign data_out       = data_out_q;
   assign busy           = busy_q;
   assign character_sent = sent_q;

endmodule
